fetch_stage: RTL and testbench

//  Instruction fetch stage: owns the PC and issues in-order requests to instruction memory.

---
 rtl/fetch_stage.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage (PC, imem requests, response FIFO); optional FETCH_BYPASS_EN
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pcplus4
);

    localparam int          PW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    // PC tags of issued, not yet returned requests (in order)
    logic [31:0]   tag_pc_q [FIFO_DEPTH];
    logic [31:0]   tag_pc_d [FIFO_DEPTH];
    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    // Instruction buffer toward decode
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_instr_d [FIFO_DEPTH];
    logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [CW:0]   credit_used;
    logic          issue;
    logic          rsp_take;
    logic          fifo_empty;
    logic          bypass;
    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   tag_head;
    logic [31:0]   if_pc;
    logic          redirect_pc_unused;

    // Low address bits of the redirect target are discarded by design
    assign redirect_pc_unused = ^i_redirect_pc[1:0];

    // Buffered words plus in-flight requests must never exceed the buffer size
    assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};
    assign o_imem_req  = (state_q == S_RUN) && !i_redirect &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign o_imem_addr = pc_q;
    assign issue       = o_imem_req && i_imem_gnt;

    // A response is kept only when nothing needs dropping and no redirect kills it
    assign rsp_take   = i_imem_rvalid && (drop_cnt_q == '0) && !i_redirect;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign tag_head   = tag_pc_q[tag_rd_q];

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_take && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word consumed by decode this cycle never enters the FIFO
    assign fifo_pop  = !fifo_empty && !i_stall && !i_redirect;
    assign fifo_push = rsp_take && !(bypass && !i_stall);

    // Decode-facing outputs: FIFO head, bypassed response, or NOP when idle
    always_comb begin
        o_if_valid = !fifo_empty || bypass;
        o_if_instr = NOP;
        if_pc      = 32'h0000_0000;
        if (!fifo_empty) begin
            o_if_instr = fifo_instr_q[fifo_rd_q];
            if_pc      = fifo_pc_q[fifo_rd_q];
        end else if (bypass) begin
            o_if_instr = i_imem_rdata;
            if_pc      = tag_head;
        end
        o_if_pc      = if_pc;
        o_if_pcplus4 = if_pc + 32'd4;
    end

    // Next-state computation; redirect is applied last so it overrides everything
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(i_imem_rvalid);
        drop_cnt_d    = drop_cnt_q;
        tag_pc_d      = tag_pc_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_cnt_d    = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);

        if (i_imem_rvalid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        if (issue) begin
            tag_pc_d[tag_wr_q] = pc_q;
            tag_wr_d           = tag_wr_q + PW'(1);
            pc_d               = pc_q + 32'd4;
        end

        if (rsp_take) begin
            tag_rd_d = tag_rd_q + PW'(1);
        end

        if (fifo_push) begin
            fifo_pc_d[fifo_wr_q]    = tag_head;
            fifo_instr_d[fifo_wr_q] = i_imem_rdata;
            fifo_wr_d               = fifo_wr_q + PW'(1);
        end

        if (fifo_pop) begin
            fifo_rd_d = fifo_rd_q + PW'(1);
        end

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_FLUSH: if (drop_cnt_d == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase

        if (i_redirect) begin
            pc_d       = {i_redirect_pc[31:2], 2'b00};
            tag_wr_d   = '0;
            tag_rd_d   = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
            drop_cnt_d = outstanding_d;
            state_d    = (outstanding_d != '0) ? S_FLUSH : S_RUN;
        end
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_pc_q[i]     <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= NOP;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
            tag_pc_q      <= tag_pc_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
        end
    end

    // Memory must not return more words than requested; buffer must not overflow
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(i_imem_rvalid && (outstanding_q == '0)));
            assert (!(fifo_push && !fifo_pop && (fifo_cnt_q == CW'(FIFO_DEPTH))));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic [31:0] o_if_pcplus4;

    logic        gnt_en  = 1'b1;
    logic        resp_en = 1'b1;
    logic [31:0] mem_q [16];
    int          mem_wr = 0;
    int          mem_rd = 0;

    logic [31:0] log_pc    [$];
    logic [31:0] log_instr [$];
    logic [31:0] log_p4    [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_if_valid    (o_if_valid),
        .o_if_instr    (o_if_instr),
        .o_if_pc       (o_if_pc),
        .o_if_pcplus4  (o_if_pcplus4)
    );

    // Memory model: in-order, answers one cycle after grant, rdata = address
    assign i_imem_gnt    = gnt_en;
    assign i_imem_rvalid = resp_en && (mem_wr != mem_rd);
    assign i_imem_rdata  = mem_q[mem_rd % 16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr <= 0;
            mem_rd <= 0;
        end else begin
            if (i_imem_rvalid) mem_rd <= mem_rd + 1;
            if (o_imem_req && i_imem_gnt) begin
                mem_q[mem_wr % 16] <= o_imem_addr;
                mem_wr             <= mem_wr + 1;
            end
            if (o_if_valid && !i_stall && !i_redirect) begin
                log_pc.push_back(o_if_pc);
                log_instr.push_back(o_if_instr);
                log_p4.push_back(o_if_pcplus4);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_head(input logic [31:0] pc, input string tag);
        int n = 0;
        while (!(o_if_valid && o_if_pc == pc) && n < 30) begin
            tick();
            n++;
        end
        check(tag, 32'(o_if_valid && o_if_pc == pc), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    32'(o_imem_req), 32'd0);
        check({tag, "_addr"},   o_imem_addr,     RPC);
        check({tag, "_valid"},  32'(o_if_valid), 32'd0);
        check({tag, "_instr"},  o_if_instr,      NOP);
        check({tag, "_pc"},     o_if_pc,         32'd0);
        check({tag, "_pcplus4"}, o_if_pcplus4,   32'd4);
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          n;

        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;

        // Reset values
        repeat (2) tick();
        check_reset_outputs("rst");

        // Boot cycle has no request; first fetch the following cycle
        rst_n = 1'b1;
        #1;
        check("boot_req", 32'(o_imem_req), 32'd0);
        tick();
        check("first_req", 32'(o_imem_req), 32'd1);
        check("first_addr", o_imem_addr, RPC);

        // Stall with pc=8 at the head for 5 cycles
        wait_head(32'h8, "head_8");
        i_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pc", o_if_pc, 32'h8);
            check("stall_valid", 32'(o_if_valid), 32'd1);
        end
        check("stall_req_off", 32'(o_imem_req), 32'd0);
        i_stall = 1'b0;
        tick();
        check("stall_req_resume", 32'(o_imem_req), 32'd1);
        repeat (10) tick();

        // In-order stream across the 2^32 wrap
        check("log_len", 32'(log_pc.size() >= 8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            exp_pc = RPC + 32'(4 * i);
            if (i < log_pc.size()) begin
                check("seq_pc", log_pc[i], exp_pc);
                check("seq_instr", log_instr[i], exp_pc);
                check("seq_pcplus4", log_p4[i], exp_pc + 32'd4);
            end
        end

        // Redirect with two requests outstanding
        resp_en = 1'b0;
        repeat (6) tick();
        check("rd1_outstanding", 32'(dut.outstanding_q), 32'd2);
        check("rd1_req_full", 32'(o_imem_req), 32'd0);
        log_pc.delete();
        log_instr.delete();
        log_p4.delete();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0103;
        #1;
        check("rd1_req_masked", 32'(o_imem_req), 32'd0);
        tick();
        i_redirect = 1'b0;
        resp_en    = 1'b1;
        check("rd1_valid_off", 32'(o_if_valid), 32'd0);
        n = 0;
        while (!o_imem_req && n < 10) begin
            tick();
            n++;
        end
        check("rd1_req_seen", 32'(o_imem_req), 32'd1);
        check("rd1_addr", o_imem_addr, 32'h0000_0100);
        wait_head(32'h100, "rd1_head");
        check("rd1_instr", o_if_instr, 32'h0000_0100);
        check("rd1_dropped", 32'(log_pc.size()), 32'd0);

        // Redirect coinciding with a response while decode stalls
        wait_head(32'h108, "head_108");
        resp_en = 1'b0;
        repeat (6) tick();
        check("rd2_outstanding", 32'(dut.outstanding_q), 32'd2);
        log_pc.delete();
        log_instr.delete();
        log_p4.delete();
        i_stall       = 1'b1;
        resp_en       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        tick();
        check("rd2_valid_off", 32'(o_if_valid), 32'd0);
        check("rd2_fifo_empty", 32'(dut.fifo_cnt_q), 32'd0);
        check("rd2_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
        i_redirect = 1'b0;
        i_stall    = 1'b0;
        wait_head(32'h200, "rd2_head");
        check("rd2_instr", o_if_instr, 32'h0000_0200);
        check("rd2_pcplus4", o_if_pcplus4, 32'h0000_0204);
        check("rd2_dropped", 32'(log_pc.size()), 32'd0);

        // Reset in the middle of a burst
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        log_pc.delete();
        log_instr.delete();
        log_p4.delete();
        wait_head(RPC, "midrst_head");
        check("midrst_instr", o_if_instr, RPC);
        check("midrst_pcplus4", o_if_pcplus4, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
